mcs4_pc_stack: RTL

//  Program counter plus parametrised return-address stack for the MCS-4 CPU core.
//  It generalises the fixed 4004 scheme (PC + 3 levels, silent circular overwrite)
//  to any address width and stack depth, and selects overflow/underflow policy by mode.

---
 rtl/mcs4_pkg.sv | 16 +
 rtl/mcs4_lifo_ram.sv | 45 ++++
 rtl/mcs4_pc_stack.sv | 97 +++++++++
 3 files changed

// File: rtl/mcs4_pkg.sv
// Shared MCS-4 core types: program-counter operation codes and default stack depth.
package mcs4_pkg;

    typedef enum logic [2:0] {
        PC_HOLD  = 3'd0,
        PC_INC   = 3'd1,
        PC_SKIP  = 3'd2,
        PC_JUMP  = 3'd3,
        PC_JPAGE = 3'd4,
        PC_CALL  = 3'd5,
        PC_RET   = 3'd6
    } pc_op_t;

    localparam int unsigned STACK_DEPTH_DEFAULT = 3;

endpackage

// File: rtl/mcs4_lifo_ram.sv
// Circular return-address storage: push writes at wr_ptr, pop steps wr_ptr back,
// tos always reads the entry just below wr_ptr.
module mcs4_lifo_ram #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] tos
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;

    // Compare-and-wrap so non-power-of-2 depths ring correctly.
    always_comb begin
        ptr_inc = (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
        ptr_dec = (wr_ptr == '0) ? LAST : wr_ptr - PTR_W'(1);
    end

    assign tos = mem[ptr_dec];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_inc;
        end else if (pop) begin
            wr_ptr <= ptr_dec;
        end
    end

endmodule

// File: rtl/mcs4_pc_stack.sv
// MCS-4 program counter with parametrised return-address stack and selectable
// overflow/underflow policy (circular 4004 behaviour or reject-and-flag).
module mcs4_pc_stack
    import mcs4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned PAGE_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEFAULT,
    parameter bit          WRAP_MODE   = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               op_valid,
    input  pc_op_t                             op,
    input  logic [ADDR_WIDTH-1:0]              target,
    input  logic                               err_clr,
    output logic [ADDR_WIDTH-1:0]              pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               full,
    output logic                               empty,
    output logic                               ovf_err,
    output logic                               unf_err
);

    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] tos;
    logic [DW-1:0]         depth_d;
    logic                  is_call;
    logic                  is_ret;
    logic                  push;
    logic                  pop;

    assign full    = (depth == DW'(STACK_DEPTH));
    assign empty   = (depth == '0);
    assign is_call = op_valid && (op == PC_CALL);
    assign is_ret  = op_valid && (op == PC_RET);
    // In reject mode an overflowing CALL or underflowing RET never touches the ring.
    assign push    = is_call && (!full || WRAP_MODE);
    assign pop     = is_ret && (!empty || WRAP_MODE);

    mcs4_lifo_ram #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_lifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc),
        .tos       (tos)
    );

    always_comb begin
        pc_d    = pc;
        depth_d = depth;
        if (op_valid) begin
            case (op)
                PC_INC:   pc_d = pc + ADDR_WIDTH'(1);
                PC_SKIP:  pc_d = pc + ADDR_WIDTH'(2);
                PC_JUMP:  pc_d = target;
                PC_JPAGE: pc_d = {pc[ADDR_WIDTH-1:PAGE_WIDTH], target[PAGE_WIDTH-1:0]};
                PC_CALL: begin
                    if (push) begin
                        pc_d = target;
                        if (!full) depth_d = depth + DW'(1);
                    end
                end
                PC_RET: begin
                    if (pop) begin
                        pc_d = tos;
                        if (!empty) depth_d = depth - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            depth   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            pc    <= pc_d;
            depth <= depth_d;
            if (is_call && full)    ovf_err <= 1'b1;
            else if (err_clr)       ovf_err <= 1'b0;
            if (is_ret && empty)    unf_err <= 1'b1;
            else if (err_clr)       unf_err <= 1'b0;
        end
    end

endmodule
